// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding, NOP word, reset PC
// and register-field positions within an instruction word.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/if_id_reg.sv
// Enable-plus-flush pipeline register carrying Instr/PC4/Valid.
// Flush inserts a bubble and takes priority over the load enable.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [N-1:0] instr_d,
  input  logic [N-1:0] pc4_d,
  output logic [N-1:0] instr_q,
  output logic [N-1:0] pc4_q,
  output logic         valid_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= N'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= N'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ready handshake, a one-entry
// hold buffer for words returned during a stall, and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              N        = 32,
  parameter logic [N-1:0]    RESET_PC = N'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             BranchTaken,
  input  logic [N-1:0]     BranchTarget,
  input  logic             Jump,
  input  logic [N-1:0]     JumpTarget,
  output logic             imem_req,
  output logic [N-1:0]     imem_addr,
  input  logic             imem_ready,
  input  logic [N-1:0]     imem_rdata,
  output logic [N-1:0]     IF_ID_Instr,
  output logic [N-1:0]     IF_ID_PC4,
  output logic             IF_ID_Valid,
  output logic [4:0]       IF_ID_Rs,
  output logic [4:0]       IF_ID_Rt,
  output logic [CNT_W-1:0] stall_count
);

  fetch_state_t state, next_state;

  logic [N-1:0] pc, pc_plus4, pc_next, hold_buf, ifid_instr_d, redirect_target;
  logic         stall, redirect;
  logic         pc_load, hold_load, ifid_en, ifid_flush;

  assign stall           = !PCWrite || !IF_ID_Write;
  assign redirect        = BranchTaken || Jump;
  assign redirect_target = BranchTaken ? BranchTarget : JumpTarget;
  assign pc_plus4        = pc + N'(4);
  assign imem_addr       = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: if (!redirect && imem_ready && stall) next_state = S_HOLD;
      S_HOLD:  if (redirect || !stall) next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req     = 1'b0;
    pc_load      = 1'b0;
    pc_next      = pc_plus4;
    hold_load    = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr_d = imem_rdata;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = redirect_target;
          ifid_flush = 1'b1;
        end else if (imem_ready && !stall) begin
          pc_load = 1'b1;
          ifid_en = 1'b1;
        end else if (imem_ready) begin
          hold_load = 1'b1;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      S_HOLD: begin
        ifid_instr_d = hold_buf;
        if (redirect) begin
          pc_load    = 1'b1;
          pc_next    = redirect_target;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          pc_load = 1'b1;
          ifid_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      hold_buf <= '0;
    end else begin
      if (pc_load)   pc       <= pc_next;
      if (hold_load) hold_buf <= imem_rdata;
    end
  end

  // Counts every stalled cycle once the pipe is running, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && state != S_IDLE && stall_count != '1)
      stall_count <= stall_count + CNT_W'(1);
  end

  if_id_reg #(.N(N)) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (ifid_en),
    .flush   (ifid_flush),
    .instr_d (ifid_instr_d),
    .pc4_d   (pc_plus4),
    .instr_q (IF_ID_Instr),
    .pc4_q   (IF_ID_PC4),
    .valid_q (IF_ID_Valid)
  );

  assign IF_ID_Rs = IF_ID_Instr[RS_MSB:RS_LSB];
  assign IF_ID_Rt = IF_ID_Instr[RT_MSB:RT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns addr ^ key.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IF_ID_Write, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt;
  logic [15:0] stall_count;
  logic [31:0] key;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;
  always_comb imem_rdata = imem_addr ^ key;

  fetch_stage #(.N(32), .RESET_PC(32'h0040_0000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .stall_count(stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, IF_ID_Instr, instr);
    check({tag, ".pc4"},   IF_ID_PC4,   pc4);
    check({tag, ".valid"}, {31'b0, IF_ID_Valid}, {31'b0, valid});
  endtask

  initial begin
    reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1;
    BranchTaken = 1'b0; Jump = 1'b0; BranchTarget = '0; JumpTarget = '0;
    imem_ready = 1'b1; key = 32'hDEAD_0000;
    #2;
    check("rst.addr", imem_addr, 32'h0040_0000);
    check("rst.req", {31'b0, imem_req}, 32'd0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.cnt", {16'b0, stall_count}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // idle cycle, then streaming fetch
    tick();
    check("idle.addr", imem_addr, 32'h0040_0000);
    check("idle.req", {31'b0, imem_req}, 32'd1);
    check("idle.valid", {31'b0, IF_ID_Valid}, 32'd0);
    tick();
    check("f1.addr", imem_addr, 32'h0040_0004);
    check_ifid("f1", 32'hDEED_0000, 32'h0040_0004, 1'b1);
    check("f1.rs", {27'b0, IF_ID_Rs}, 32'h17);
    check("f1.rt", {27'b0, IF_ID_Rt}, 32'h0D);
    tick();
    check("f2.addr", imem_addr, 32'h0040_0008);
    check_ifid("f2", 32'hDEED_0004, 32'h0040_0008, 1'b1);

    // stall with ready: word captured in hold buffer
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    tick();
    check("h1.req", {31'b0, imem_req}, 32'd0);
    check("h1.addr", imem_addr, 32'h0040_0008);
    check_ifid("h1", 32'hDEED_0004, 32'h0040_0008, 1'b1);
    tick(); tick();
    check("h3.cnt", {16'b0, stall_count}, 32'd3);
    check("h3.addr", imem_addr, 32'h0040_0008);
    key = 32'h1111_0000;
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    tick();
    check("hrel.addr", imem_addr, 32'h0040_000C);
    check_ifid("hrel", 32'hDEED_0008, 32'h0040_000C, 1'b1);
    check("hrel.cnt", {16'b0, stall_count}, 32'd3);

    // branch + jump together while stalled
    PCWrite = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'h0040_0100;
    Jump = 1'b1; JumpTarget = 32'h0040_0200;
    tick();
    check("br.addr", imem_addr, 32'h0040_0100);
    check_ifid("br", 32'h0, 32'h0, 1'b0);
    check("br.req", {31'b0, imem_req}, 32'd1);
    check("br.cnt", {16'b0, stall_count}, 32'd4);

    // redirect out of the hold state by a jump alone
    BranchTaken = 1'b0; Jump = 1'b0;
    tick();
    check("h2.req", {31'b0, imem_req}, 32'd0);
    Jump = 1'b1;
    tick();
    check("jh.addr", imem_addr, 32'h0040_0200);
    check("jh.req", {31'b0, imem_req}, 32'd1);
    check("jh.valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("jh.cnt", {16'b0, stall_count}, 32'd6);
    Jump = 1'b0; PCWrite = 1'b1;

    // memory not ready: bubbles, PC constant
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wait.req", {31'b0, imem_req}, 32'd1);
      check("wait.addr", imem_addr, 32'h0040_0200);
      check("wait.valid", {31'b0, IF_ID_Valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    check("rdy.addr", imem_addr, 32'h0040_0204);
    check_ifid("rdy", 32'h1151_0200, 32'h0040_0204, 1'b1);

    // not ready while stalled: everything held
    imem_ready = 1'b0; IF_ID_Write = 1'b0;
    tick();
    check("nrs.addr", imem_addr, 32'h0040_0204);
    check_ifid("nrs", 32'h1151_0200, 32'h0040_0204, 1'b1);
    check("nrs.cnt", {16'b0, stall_count}, 32'd7);
    imem_ready = 1'b1;
    tick();
    check("nrs.hold", {31'b0, imem_req}, 32'd0);

    // asynchronous reset between edges while holding
    #2 reset = 1'b1;
    #1;
    check("arst.addr", imem_addr, 32'h0040_0000);
    check("arst.req", {31'b0, imem_req}, 32'd0);
    check_ifid("arst", 32'h0, 32'h0, 1'b0);
    check("arst.cnt", {16'b0, stall_count}, 32'd0);
    #1 reset = 1'b0; IF_ID_Write = 1'b1;
    tick();
    tick();
    check("rs.addr", imem_addr, 32'h0040_0004);
    check_ifid("rs", 32'h1151_0000, 32'h0040_0004, 1'b1);

    // PC wrap
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    tick();
    check("wrap.j", imem_addr, 32'hFFFF_FFFC);
    Jump = 1'b0;
    tick();
    check("wrap.addr", imem_addr, 32'h0000_0000);
    check_ifid("wrap", 32'hEEEE_FFFC, 32'h0000_0000, 1'b1);

    // stall counter saturation
    PCWrite = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    check("sat.edge", {16'b0, stall_count}, 32'h0000_FFFF);
    for (int i = 0; i < 6; i++) tick();
    check("sat.hold", {16'b0, stall_count}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC and the IF/ID pipeline register.
- It consumes PCWrite / IF_ID_Write from the hazard detection unit and redirect requests from the branch/jump logic.
- It talks to instruction memory through a req/ready handshake and feeds the decode stage plus the hazard unit's IF_ID_Rs/IF_ID_Rt (bits 25:21 / 20:16 of IF_ID_Instr).

Parameters:
- N, 32, data/address width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- PCWrite  input  1  from hazard unit; 0 = freeze PC.
- IF_ID_Write  input  1  from hazard unit; 0 = freeze IF/ID register.
- BranchTaken  input  1  taken branch resolved downstream.
- BranchTarget  input  N  branch target address.
- Jump  input  1  jump decoded in ID.
- JumpTarget  input  N  jump target address.
- imem_req  output  1  fetch request, valid while waiting for memory.
- imem_addr  output  N  fetch address (= PC register).
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  N  fetched instruction.
- IF_ID_Instr  output  N  instruction to ID stage.
- IF_ID_PC4  output  N  PC+4 of that instruction.
- IF_ID_Valid  output  1  0 = bubble.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - PC=RESET_PC, state=S_IDLE.
  - IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0.
  - Hold buffer empty; stall_count=0; imem_req=0.
- Derived signals:
  - stall = !PCWrite || !IF_ID_Write. Both inputs are treated as one stall.
  - redirect = BranchTaken || Jump.
  - Redirect target: BranchTaken has priority over Jump, so target = BranchTaken ? BranchTarget : JumpTarget.
- Outputs: imem_addr = PC at all times; imem_req = (state==S_FETCH).
- FSM states: S_IDLE, S_FETCH, S_HOLD.
  - S_IDLE: the one cycle after reset release, then -> S_FETCH. IF/ID is unchanged.
- S_FETCH, evaluated in priority order:
  - a) redirect: PC<=target; IF/ID<=bubble; any imem_rdata this cycle is discarded; stay S_FETCH. This wins over stall.
  - b) imem_ready && !stall: IF_ID_Instr<=imem_rdata, IF_ID_PC4<=PC+4, IF_ID_Valid<=1; PC<=PC+4; stay.
  - c) imem_ready && stall: hold buffer<=imem_rdata; PC and IF/ID unchanged; -> S_HOLD. The instruction is never re-fetched.
  - d) !imem_ready && !stall: IF/ID<=bubble; PC unchanged; stay.
  - e) !imem_ready && stall: IF/ID and PC unchanged; stay.
- S_HOLD (imem_req=0):
  - a) redirect: PC<=target; IF/ID<=bubble; buffer dropped; -> S_FETCH.
  - b) !stall: IF/ID<=buffer with PC4=PC+4, Valid=1; PC<=PC+4; -> S_FETCH.
  - c) stall: hold everything; stay.
- Bubble definition: Instr=0 (sll $0,$0,0), PC4=0, Valid=0.
- Address arithmetic: PC+4 is modulo 2^N; wrap from 32'hFFFF_FFFC to 0 is legal.
- Latency: fetch issued in cycle t with ready in t produces IF/ID valid at edge t+1. No combinational path from imem_rdata to the IF/ID outputs.
- stall_count:
  - +1 on each clock with stall=1 and state!=S_IDLE.
  - Saturates at 2^CNT_W-1; cleared only by reset.

Decomposition:
- Shared package mips_pkg:
  - fetch state enum (S_IDLE/S_FETCH/S_HOLD);
  - NOP_INSTR=32'h0000_0000;
  - RESET_PC default;
  - field-slice constants RS_MSB/RS_LSB, RT_MSB/RT_LSB.
- One natural sub-module, if_id_reg:
  - enable-plus-flush pipeline register (Instr, PC4, Valid);
  - shared later with the ID/EX bubble path.

Test Plan:
- Reset then imem_ready tied 1, no stall -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; IF_ID_PC4 lags by one cycle with Valid=1.
- imem_ready=1, PCWrite=IF_ID_Write=0 for 3 cycles at PC 0x00400008 -> S_HOLD; imem_req=0; PC and IF/ID frozen; stall_count=3. On release, the buffered instruction appears in IF/ID and PC=0x0040000C.
- BranchTaken=1 with target 0x00400100 and Jump=1 with target 0x00400200 while stalled -> PC=0x00400100, IF_ID_Valid=0 next cycle; branch priority and redirect-over-stall both confirmed.
- imem_ready low for 4 cycles, no stall -> imem_req held 1; IF/ID shows bubbles; PC constant; rdata accepted on the cycle ready rises.
- reset asserted asynchronously between clock edges while in S_HOLD -> outputs go to reset values immediately; after release, fetch restarts at 0x00400000.
- PC=0xFFFFFFFC fetched -> next imem_addr=0x00000000, IF_ID_PC4=0x00000000; 2^16+5 stall cycles -> stall_count=0xFFFF.
